act_row_feeder: RTL and testbench

Streams a raster-order feature map of CH-channel pixel words into the three row inputs of the 64-channel activation register file. Two internal line buffers hold the previous two input rows. For every accepted pixel, the block presents a vertically aligned column triplet with a one-cycle `act_load` strobe. The block sits between the activation SRAM reader and the activation register file, and gives the 3×3 sliding-patch stage its row-aligned feed.

---
 rtl/act_feeder_pkg.sv | 30 +++
 rtl/act_line_buffer.sv | 40 ++++
 rtl/act_row_feeder.sv | 227 ++++++++++++++++++++++
 tb/tb_act_row_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_feeder_pkg.sv
// ----------------------------------------------------------------------------
// act_feeder_pkg
// Shared definitions for the activation row feeder:
//   - default geometry (element width, channels per pixel, maximum frame width)
//   - packed pixel width PIX_W
//   - cnt_width(): address/counter width helper (never narrower than 1 bit)
//   - state_t: feeder FSM states
// ----------------------------------------------------------------------------
package act_feeder_pkg;

   localparam int ACT_DATA_WIDTH = 16;
   localparam int ACT_CH         = 64;
   localparam int ACT_MAX_W      = 224;
   localparam int PIX_W          = ACT_DATA_WIDTH * ACT_CH;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_STREAM,
      S_PAD_L,
      S_PAD_R,
      S_FLUSH,
      S_DONE
   } state_t;

endpackage

// File: rtl/act_line_buffer.sv
// ----------------------------------------------------------------------------
// act_line_buffer
// Simple dual-port line memory, DEPTH x WIDTH, read-first, registered read.
// The read register only updates when i_re is high, so it holds its value
// between reads.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read port (enable, address)
//   o_rdata          registered read data (old contents on same-address write)
// ----------------------------------------------------------------------------
module act_line_buffer #(
   parameter int DEPTH = 224,
   parameter int WIDTH = 1024,
   parameter int AW    = 8
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/act_row_feeder.sv
// ----------------------------------------------------------------------------
// act_row_feeder
// Turns a raster-order stream of CH-channel pixel words into vertically
// aligned column triplets (row r-2, row r-1, row r) for the activation
// register file. Two line buffers keep the previous two input rows.
//
// Optional feature macro: ACT_FEEDER_PAD_EN
//   undefined : rows 0-1 only fill the buffers; (H-2) x W triplets per frame
//   defined   : 1-pixel zero border; H x (W+2) triplets per frame
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_cfg_width, i_cfg_height   frame start and geometry (IDLE only)
//   i_in_valid, o_in_ready, i_in_data    pixel input handshake
//   i_act_ready                  consumer can take a triplet this cycle
//   o_act_load                   one-cycle triplet strobe
//   o_data_first/second/third_row  triplet (top, middle, bottom)
//   o_busy                       frame in progress
//   o_frame_done                 pulse the cycle after the last triplet
//   o_cfg_err                    pulse when a start request is rejected
// ----------------------------------------------------------------------------
module act_row_feeder
   import act_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = ACT_DATA_WIDTH,
   parameter int CH         = ACT_CH,
   parameter int MAX_W      = ACT_MAX_W
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [$clog2(MAX_W+1)-1:0]   i_cfg_width,
   input  logic [15:0]                  i_cfg_height,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   input  logic [DATA_WIDTH*CH-1:0]     i_in_data,
   input  logic                         i_act_ready,
   output logic                         o_act_load,
   output logic [DATA_WIDTH*CH-1:0]     o_data_first_row,
   output logic [DATA_WIDTH*CH-1:0]     o_data_second_row,
   output logic [DATA_WIDTH*CH-1:0]     o_data_third_row,
   output logic                         o_busy,
   output logic                         o_frame_done,
   output logic                         o_cfg_err
);

   localparam int PW = DATA_WIDTH * CH;
   localparam int WW = $clog2(MAX_W + 1);
   localparam int AW = cnt_width(MAX_W);

`ifdef ACT_FEEDER_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   state_t          r_state, w_state_next;
   logic [WW-1:0]   r_col, r_width;
   logic [15:0]     r_row, r_height;
   logic            r_swap, r_flush;
   logic            r_act_load, r_frame_done, r_cfg_err;
   logic            r_top_zero, r_mid_zero, r_bot_zero, r_top_from_b;
   logic [PW-1:0]   r_bot_data;

   logic            w_cfg_ok, w_in_ready, w_accept, w_emit_pix, w_emit_pad;
   logic            w_top_zero, w_bot_zero, w_col_end, w_row_end, w_start_ok;
   logic [AW-1:0]   w_addr;
   logic [1:0]      w_we;
   logic [PW-1:0]   w_rdata [2];

   // Instead of copying lb1 into lb0 on every pixel, the two physical buffers
   // swap roles at each row wrap: the buffer holding row r-2 takes the new
   // pixel (read-first returns the old row r-2 value in the same cycle).
   // r_swap = 0: buffer 0 is lb0 (row r-2), buffer 1 is lb1 (row r-1).
   assign w_addr  = r_col[AW-1:0];
   assign w_we[0] = w_accept && !r_swap;
   assign w_we[1] = w_accept &&  r_swap;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lb
         act_line_buffer #(.DEPTH(MAX_W), .WIDTH(PW), .AW(AW)) u_lb (
            .i_clk   (i_clk),
            .i_we    (w_we[gi]),
            .i_waddr (w_addr),
            .i_wdata (i_in_data),
            .i_re    (w_emit_pix),
            .i_raddr (w_addr),
            .o_rdata (w_rdata[gi])
         );
      end
   endgenerate

   always_comb begin
      w_cfg_ok     = (32'(i_cfg_width) >= 32'd3) && (32'(i_cfg_width) <= 32'(MAX_W))
                     && (i_cfg_height >= 16'd3);
      w_start_ok   = (r_state == S_IDLE) && i_start && w_cfg_ok;
      w_col_end    = (r_col == r_width - WW'(1));
      w_row_end    = (r_row == r_height - 16'd1);
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_emit_pix   = 1'b0;
      w_emit_pad   = 1'b0;
      w_top_zero   = 1'b0;
      w_bot_zero   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_next = S_FILL;
         end
         S_FILL: begin
            w_in_ready = 1'b1;
            // Padded frames fill row 0 only; unpadded frames fill rows 0 and 1.
            if (i_in_valid && w_col_end && (PAD_EN || r_row == 16'd1)) begin
               if (PAD_EN) w_state_next = S_PAD_L;
               else        w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            w_in_ready = i_act_ready;
            w_emit_pix = i_in_valid && i_act_ready;
            w_top_zero = PAD_EN && (r_row == 16'd1);
            if (w_emit_pix && w_col_end) begin
               if (PAD_EN)         w_state_next = S_PAD_R;
               else if (w_row_end) w_state_next = S_DONE;
            end
         end
         S_PAD_L: begin
            w_emit_pad = i_act_ready;
            if (i_act_ready) begin
               if (r_flush) w_state_next = S_FLUSH;
               else         w_state_next = S_STREAM;
            end
         end
         S_PAD_R: begin
            w_emit_pad = i_act_ready;
            if (i_act_ready) begin
               if (r_flush) w_state_next = S_DONE;
               else         w_state_next = S_PAD_L;
            end
         end
         S_FLUSH: begin
            // Final padded output row: buffers only, bottom row is the border.
            w_emit_pix = i_act_ready;
            w_bot_zero = 1'b1;
            if (i_act_ready && w_col_end) w_state_next = S_PAD_R;
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      w_accept = i_in_valid && w_in_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_col        <= '0;
         r_row        <= '0;
         r_width      <= '0;
         r_height     <= '0;
         r_swap       <= 1'b0;
         r_flush      <= 1'b0;
         r_act_load   <= 1'b0;
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_top_zero   <= 1'b1;
         r_mid_zero   <= 1'b1;
         r_bot_zero   <= 1'b1;
         r_top_from_b <= 1'b0;
         r_bot_data   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_act_load   <= w_emit_pix || w_emit_pad;
         r_frame_done <= (r_state == S_DONE);
         r_cfg_err    <= (r_state == S_IDLE) && i_start && !w_cfg_ok;
         if (w_start_ok) begin
            r_width  <= i_cfg_width;
            r_height <= i_cfg_height;
            r_col    <= '0;
            r_row    <= '0;
            r_swap   <= 1'b0;
            r_flush  <= 1'b0;
         end
         if (w_accept || (r_state == S_FLUSH && w_emit_pix)) begin
            if (w_col_end) begin
               r_col <= '0;
               if (w_accept) begin
                  r_row  <= r_row + 16'd1;
                  r_swap <= ~r_swap;
               end
            end else begin
               r_col <= r_col + WW'(1);
            end
         end
         // Every input row consumed: the next output row is the flush row.
         if (r_state == S_PAD_R && w_emit_pad && r_row == r_height) begin
            r_flush <= 1'b1;
         end
         // Output selects are captured with the triplet so the data outputs
         // hold their value whenever no new triplet is emitted.
         if (w_emit_pix) begin
            r_top_zero   <= w_top_zero;
            r_mid_zero   <= 1'b0;
            r_bot_zero   <= w_bot_zero;
            r_top_from_b <= r_swap;
            r_bot_data   <= i_in_data;
         end else if (w_emit_pad) begin
            r_top_zero <= 1'b1;
            r_mid_zero <= 1'b1;
            r_bot_zero <= 1'b1;
         end
      end
   end

   assign o_in_ready        = w_in_ready;
   assign o_act_load        = r_act_load;
   assign o_busy            = (r_state != S_IDLE);
   assign o_frame_done      = r_frame_done;
   assign o_cfg_err         = r_cfg_err;
   assign o_data_first_row  = r_top_zero ? '0 : (r_top_from_b ? w_rdata[1] : w_rdata[0]);
   assign o_data_second_row = r_mid_zero ? '0 : (r_top_from_b ? w_rdata[0] : w_rdata[1]);
   assign o_data_third_row  = r_bot_zero ? '0 : r_bot_data;

endmodule

// File: tb/tb_act_row_feeder.sv
`timescale 1ns/1ps
module tb_act_row_feeder;

   localparam int DW   = 16;
   localparam int NCH  = 4;
   localparam int MAXW = 224;
   localparam int PW   = DW * NCH;
   localparam int WW   = $clog2(MAXW + 1);
`ifdef ACT_FEEDER_PAD_EN
   localparam bit PADV = 1'b1;
`else
   localparam bit PADV = 1'b0;
`endif

   typedef logic [3*PW-1:0] trip_t;
   typedef struct {
      int w;
      int h;
      int rdy_mode;     // 0 always ready, 1 random, 2 pattern 1-0-0-1
      int vld_mode;     // 0 always valid, 1 random
      bit exp_err;
      int exp_strobes;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, in_ready, act_ready, act_load;
   logic [WW-1:0] cfg_width;
   logic [15:0]   cfg_height;
   logic [PW-1:0] in_data, d1, d2, d3;
   logic          busy, frame_done, cfg_err;

   always #5 clk = ~clk;

   act_row_feeder #(.DATA_WIDTH(DW), .CH(NCH), .MAX_W(MAXW)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_cfg_width(cfg_width), .i_cfg_height(cfg_height),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .i_act_ready(act_ready), .o_act_load(act_load),
      .o_data_first_row(d1), .o_data_second_row(d2), .o_data_third_row(d3),
      .o_busy(busy), .o_frame_done(frame_done), .o_cfg_err(cfg_err)
   );

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    salt = 0;
   trip_t got_q[$];
   trip_t exp_q[$];
   trip_t last_trip = '0;
   bit    mon_en = 1'b0;
   int    fd_cnt, fd_cyc, ld_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input trip_t act, input trip_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Lane 0 = r*16+c, then row, column and a per-frame salt.
   function automatic logic [PW-1:0] pix(input int r, input int c);
      return {16'(r * 16 + c), 16'(r), 16'(c), 16'(salt)};
   endfunction

   function automatic logic [47:0] lanes0(input trip_t t);
      return {t[3*PW-1 -: 16], t[2*PW-1 -: 16], t[PW-1 -: 16]};
   endfunction

   // Reference: list every triplet a frame must produce, from the frame image.
   task automatic build_exp(input int w, input int h);
      logic [PW-1:0] z;
      z = '0;
      exp_q.delete();
      if (PADV) begin
         for (int r = 0; r < h; r++) begin
            exp_q.push_back('0);
            for (int c = 0; c < w; c++)
               exp_q.push_back({(r > 0) ? pix(r - 1, c) : z, pix(r, c),
                                (r < h - 1) ? pix(r + 1, c) : z});
            exp_q.push_back('0);
         end
      end else begin
         for (int r = 2; r < h; r++)
            for (int c = 0; c < w; c++)
               exp_q.push_back({pix(r - 2, c), pix(r - 1, c), pix(r, c)});
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (act_load) begin
            got_q.push_back({d1, d2, d3});
            last_trip = {d1, d2, d3};
            ld_cyc = cyc;
         end else begin
            check("hold", {d1, d2, d3}, last_trip);
         end
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
      end
   end

   task automatic drive(input int idx, input int w, input int total,
                        input int rdy_mode, input int vld_mode, input int k);
      case (rdy_mode)
         0:       act_ready = 1'b1;
         1:       act_ready = 1'($urandom_range(0, 1));
         default: act_ready = (k % 4 == 0) || (k % 4 == 3);
      endcase
      in_valid = (idx < total) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
      in_data  = in_valid ? pix(idx / w, idx % w) : {$urandom, $urandom};
   endtask

   task automatic run_frame(input int w, input int h, input int rdy_mode,
                            input int vld_mode, input int exp_strobes, input string tag);
      int idx, total, fill_px, budget, n;
      bit acc, done;
      idx = 0; total = w * h; done = 1'b0;
      fill_px = PADV ? w : 2 * w;
      budget = total * 10 + 200;
      salt++;
      build_exp(w, h);
      got_q.delete();
      fd_cnt = 0; fd_cyc = -1; ld_cyc = -100;
      cfg_width = WW'(w); cfg_height = 16'(h); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drive(idx, w, total, rdy_mode, vld_mode, 0);
      for (int k = 1; k < budget && !done; k++) begin
         @(negedge clk);
         if (idx < fill_px)
            check($sformatf("%s_fill_ready", tag), in_ready, 1);
         else if (rdy_mode == 2 && idx < total) begin
`ifdef ACT_FEEDER_PAD_EN
            check($sformatf("%s_ready_stall", tag), in_ready && !act_ready, 0);
`else
            check($sformatf("%s_ready_track", tag), in_ready, act_ready);
`endif
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         if (fd_cnt > 0) done = 1'b1;
         drive(idx, w, total, rdy_mode, vld_mode, k);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s_frame_done_seen", tag), fd_cnt, 1);
      check($sformatf("%s_strobes", tag), got_q.size(), exp_strobes);
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_trip%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_fd_timing", tag), fd_cyc, ld_cyc + 1);
      check($sformatf("%s_busy_after", tag), busy, 0);
      $display("frame %s W=%0d H=%0d: %0d triplets", tag, w, h, got_q.size());
   endtask

   task automatic bad_cfg(input int w, input int h, input string tag);
      cfg_width = WW'(w); cfg_height = 16'(h);
      start = 1'b1; in_valid = 1'b1; act_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("%s_cfg_err_pulse", tag), cfg_err, 1);
      check($sformatf("%s_busy", tag), busy, 0);
      check($sformatf("%s_no_accept", tag), in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("%s_cfg_err_clear", tag), cfg_err, 0);
      check($sformatf("%s_busy2", tag), busy, 0);
      check($sformatf("%s_no_accept2", tag), in_ready, 0);
      in_valid = 1'b0;
      $display("bad config %s W=%0d H=%0d", tag, w, h);
   endtask

   function automatic vec_t mk(input int w, input int h, input int r, input int v, input bit err);
      vec_t t;
      t.w = w; t.h = h; t.rdy_mode = r; t.vld_mode = v; t.exp_err = err;
      t.exp_strobes = PADV ? h * (w + 2) : (h - 2) * w;
      return t;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_act_load"}, act_load, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_cfg_err"}, cfg_err, 0);
      check({tag, "_data"}, {d1, d2, d3}, '0);
   endtask

   vec_t vt[10];

   initial begin
      int acc_cnt;
      bit acc;
      vt[0] = mk(4, 4, 0, 0, 0);
      vt[1] = mk(4, 4, 2, 0, 0);
      vt[2] = mk(MAXW, 3, 0, 0, 0);
      vt[3] = mk(2, 4, 0, 0, 1);
      vt[4] = mk(4, 2, 0, 0, 1);
      vt[5] = mk(MAXW + 1, 4, 0, 0, 1);
      vt[6] = mk(3, 3, 1, 1, 0);
      vt[7] = mk(7, 5, 1, 1, 0);
      vt[8] = mk(5, 6, 2, 1, 0);
      vt[9] = mk(3, 3, 0, 0, 0);

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; act_ready = 1'b0;
      in_data = '0; cfg_width = '0; cfg_height = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      last_trip = '0;
      mon_en = 1'b1;

      for (int i = 0; i < 10; i++) begin
         if (vt[i].exp_err)
            bad_cfg(vt[i].w, vt[i].h, $sformatf("vec%0d", i));
         else
            run_frame(vt[i].w, vt[i].h, vt[i].rdy_mode, vt[i].vld_mode,
                      vt[i].exp_strobes, $sformatf("vec%0d", i));
      end

      // Test-plan frame with literal first/last triplet values (lane 0).
      run_frame(4, 4, 0, 0, PADV ? 24 : 8, "plan4x4");
`ifdef ACT_FEEDER_PAD_EN
      check("plan_first_zero", got_q[0], '0);
      check("plan_second", lanes0(got_q[1]), 48'h0000_0000_0010);
      check("plan_flush_last", lanes0(got_q[22]), 48'h0023_0033_0000);
`else
      check("plan_first", lanes0(got_q[0]), 48'h0000_0010_0020);
      check("plan_last", lanes0(got_q[7]), 48'h0013_0023_0033);
`endif

      // Max width: column MAXW-1 of the middle output row.
      run_frame(MAXW, 3, 0, 0, PADV ? 3 * (MAXW + 2) : MAXW, "maxw");
`ifdef ACT_FEEDER_PAD_EN
      check("maxw_lastcol", lanes0(got_q[(MAXW + 2) + MAXW]), 48'h00DF_00EF_00FF);
`else
      check("maxw_lastcol", lanes0(got_q[MAXW - 1]), 48'h00DF_00EF_00FF);
`endif

      // Reset after 6 accepted pixels, then a clean frame.
      salt++;
      cfg_width = WW'(4); cfg_height = 16'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      acc_cnt = 0;
      in_valid = 1'b1; act_ready = 1'b1; in_data = pix(0, 0);
      for (int k = 0; k < 50 && acc_cnt < 6; k++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) acc_cnt++;
         in_data = pix(acc_cnt / 4, acc_cnt % 4);
      end
      check("rst_mid_accepted", acc_cnt, 6);
      in_valid = 1'b0; rst = 1'b1; mon_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("rst_mid");
      last_trip = '0;
      mon_en = 1'b1;
      run_frame(4, 4, 1, 1, PADV ? 24 : 8, "post_rst");

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
